// File: rtl/qed_pkg.sv
// Shared types for the QED commit checker: FSM states, error causes, FIFO entry and rd decode.
package qed_pkg;

    localparam logic [4:0] QED_DUP_OFFSET = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ORIG = 2'd1,
        ST_DUP  = 2'd2,
        ST_ERR  = 2'd3
    } qed_state_e;

    typedef enum logic [1:0] {
        CAUSE_MISMATCH  = 2'd0,
        CAUSE_UNDERFLOW = 2'd1,
        CAUSE_OVERFLOW  = 2'd2,
        CAUSE_LEFTOVER  = 2'd3
    } qed_cause_e;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_ORIG = 2'd1,
        RD_DUP  = 2'd2
    } rd_class_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } qed_entry_t;

    // rd 0 and 16 carry no QED meaning; bit 4 separates duplicates from originals.
    function automatic rd_class_e qed_rd_class(input logic [4:0] rd);
        if (rd[3:0] == 4'd0) return RD_NONE;
        return rd[4] ? RD_DUP : RD_ORIG;
    endfunction

endpackage

// File: rtl/qed_result_fifo.sv
// Synchronous FIFO of original-instruction results; head is read combinationally.
module qed_result_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 37
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/qed_commit_checker.sv
// Pairs original and duplicate writebacks in order and raises a sticky QED error.
// Optional error log ports are enabled by defining QED_CHK_ERR_LOG_EN.
module qed_commit_checker
    import qed_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned STALL_MARGIN = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             exec_dup,
    input  logic             dup_done,
    input  logic             wb_vld,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    output logic             stall_IF_chk,
    output logic             qed_error,
    output logic [1:0]       err_cause,
    output logic             check_ok,
    output logic [CNT_W-1:0] pair_count
`ifdef QED_CHK_ERR_LOG_EN
   ,output logic [4:0]       err_rd,
    output logic [31:0]      err_orig_data,
    output logic [31:0]      err_dup_data
`endif
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] STALL_TH = (AW+1)'(DEPTH - STALL_MARGIN);

    qed_state_e       r_state;
    qed_state_e       w_next;
    logic             r_exec_dup_d;
    logic             r_qed_error;
    qed_cause_e       r_err_cause;
    logic             r_check_ok;
    logic [CNT_W-1:0] r_pair_count;

    rd_class_e  w_cls;
    logic       w_active, w_wb_orig, w_wb_dup, w_dup_done, w_dup_edge;
    logic       w_push, w_pop, w_flush, w_match, w_left_nz;
    logic       w_err;
    qed_cause_e w_cause;
    qed_entry_t w_head;
    qed_entry_t w_wentry;
    logic [4:0] w_dup_rd;
    logic [AW:0] w_count;
    logic       w_full, w_empty;

    assign w_cls      = qed_rd_class(wb_rd);
    assign w_active   = (r_state == ST_ORIG || r_state == ST_DUP) && ena;
    assign w_wb_orig  = w_active && wb_vld && (w_cls == RD_ORIG);
    assign w_wb_dup   = w_active && wb_vld && (w_cls == RD_DUP);
    assign w_dup_done = w_active && (r_state == ST_DUP) && dup_done;
    assign w_dup_edge = exec_dup && !r_exec_dup_d;
    assign w_dup_rd   = wb_rd - QED_DUP_OFFSET;
    assign w_wentry   = '{rd: wb_rd, data: wb_data};
    assign w_match    = w_wb_dup && !w_empty && (w_head.rd == w_dup_rd) && (w_head.data == wb_data);
    // Occupancy as it will be after this cycle's push/pop, so a pop of the last entry alongside dup_done is not a leftover.
    assign w_left_nz  = w_push || ((w_count != '0) && !((w_count == (AW+1)'(1)) && w_pop));

    qed_result_fifo #(.DEPTH(DEPTH), .WIDTH(37)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata (w_wentry),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_err   = 1'b0;
        w_cause = CAUSE_MISMATCH;
        if (w_wb_orig && w_full) begin
            w_err = 1'b1; w_cause = CAUSE_OVERFLOW;
        end else if (w_wb_dup && w_empty) begin
            w_err = 1'b1; w_cause = CAUSE_UNDERFLOW;
        end else if (w_wb_dup && !w_match) begin
            w_err = 1'b1; w_cause = CAUSE_MISMATCH;
        end else if (w_dup_done && w_left_nz) begin
            w_err = 1'b1; w_cause = CAUSE_LEFTOVER;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (ena) w_next = ST_ORIG;
            ST_ORIG: begin
                if (!ena)            w_next = ST_IDLE;
                else if (w_err)      w_next = ST_ERR;
                else if (w_dup_edge) w_next = ST_DUP;
            end
            ST_DUP: begin
                if (!ena)          w_next = ST_IDLE;
                else if (w_err)    w_next = ST_ERR;
                else if (dup_done) w_next = ST_ORIG;
            end
            ST_ERR: w_next = ST_ERR;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_push       = w_wb_orig && !w_full;
        w_pop        = w_wb_dup && !w_empty;
        w_flush      = (r_state == ST_ORIG || r_state == ST_DUP) && !ena;
        stall_IF_chk = (r_state == ST_ORIG || r_state == ST_DUP) && (w_count >= STALL_TH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_exec_dup_d <= 1'b0;
            r_qed_error  <= 1'b0;
            r_err_cause  <= CAUSE_MISMATCH;
            r_check_ok   <= 1'b0;
            r_pair_count <= '0;
        end else begin
            r_exec_dup_d <= exec_dup;
            r_check_ok   <= w_dup_done && !w_err;
            if (w_err && !r_qed_error) begin
                r_qed_error <= 1'b1;
                r_err_cause <= w_cause;
            end
            if (w_match && (r_pair_count != '1)) r_pair_count <= r_pair_count + 1'b1;
        end
    end

    assign qed_error  = r_qed_error;
    assign err_cause  = r_err_cause;
    assign check_ok   = r_check_ok;
    assign pair_count = r_pair_count;

`ifdef QED_CHK_ERR_LOG_EN
    logic [4:0]  r_err_rd;
    logic [31:0] r_err_orig, r_err_dup;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_rd   <= '0;
            r_err_orig <= '0;
            r_err_dup  <= '0;
        end else if (w_err && !r_qed_error) begin
            unique case (w_cause)
                CAUSE_OVERFLOW:  begin r_err_rd <= wb_rd;     r_err_orig <= wb_data;     r_err_dup <= '0;      end
                CAUSE_UNDERFLOW: begin r_err_rd <= wb_rd;     r_err_orig <= '0;          r_err_dup <= wb_data; end
                CAUSE_MISMATCH:  begin r_err_rd <= wb_rd;     r_err_orig <= w_head.data; r_err_dup <= wb_data; end
                default:         begin r_err_rd <= w_head.rd; r_err_orig <= w_head.data; r_err_dup <= '0;      end
            endcase
        end
    end

    assign err_rd        = r_err_rd;
    assign err_orig_data = r_err_orig;
    assign err_dup_data  = r_err_dup;
`endif

endmodule

// File: tb/tb_qed_commit_checker.sv
// Scoreboard bench for qed_commit_checker: expected check_ok/error events are queued by stimulus, popped by a monitor.
module tb_qed_commit_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        exec_dup = 1'b0;
    logic        dup_done = 1'b0;
    logic        wb_vld = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        stall_IF_chk;
    logic        qed_error;
    logic [1:0]  err_cause;
    logic        check_ok;
    logic [15:0] pair_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        bit         is_err;
        logic [1:0] cause;
    } exp_t;
    exp_t exp_q[$];

    qed_commit_checker #(.DEPTH(16), .STALL_MARGIN(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .exec_dup     (exec_dup),
        .dup_done     (dup_done),
        .wb_vld       (wb_vld),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .stall_IF_chk (stall_IF_chk),
        .qed_error    (qed_error),
        .err_cause    (err_cause),
        .check_ok     (check_ok),
        .pair_count   (pair_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data);
        wb_vld = 1'b1; wb_rd = rd; wb_data = data;
        tick();
        wb_vld = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic expect_ok();
        exp_t e; e.is_err = 1'b0; e.cause = 2'd0; exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [1:0] cause);
        exp_t e; e.is_err = 1'b1; e.cause = cause; exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b0; ena = 1'b0; exec_dup = 1'b0; dup_done = 1'b0;
        wb_vld = 1'b0; wb_rd = '0; wb_data = '0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
        chk(nm, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every check_ok pulse or rising qed_error must match the queue head.
    logic prev_err = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            prev_err = 1'b0;
        end else begin
            if (check_ok) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_check_ok: got=1 expected=no event");
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_check_ok", {31'd0, e.is_err}, 32'd0);
                end
            end
            if (qed_error && !prev_err) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_qed_error: cause=%0d expected=no event", err_cause);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_is_error", 32'd1, {31'd0, e.is_err});
                    chk("err_cause", {30'd0, err_cause}, {30'd0, e.cause});
                end
            end
            prev_err = qed_error;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset state and one matched block
        do_reset();
        rst = 1'b0; tick();
        chk("rst_qed_error", {31'd0, qed_error}, 0);
        chk("rst_err_cause", {30'd0, err_cause}, 0);
        chk("rst_check_ok", {31'd0, check_ok}, 0);
        chk("rst_stall", {31'd0, stall_IF_chk}, 0);
        chk("rst_pair_count", {16'd0, pair_count}, 0);
        rst = 1'b1;
        ena = 1'b1; tick();
        wb(5'd5, 32'hA5);
        exec_dup = 1'b1; tick();
        wb(5'd21, 32'hA5);
        expect_ok();
        dup_done = 1'b1; tick(); dup_done = 1'b0;
        exec_dup = 1'b0; tick(); tick();
        chk("t1_pair_count", {16'd0, pair_count}, 1);
        chk("t1_qed_error", {31'd0, qed_error}, 0);
        drain("t1_drain");

        // 2: data mismatch, sticky across ena toggles
        do_reset();
        ena = 1'b1; tick();
        wb(5'd3, 32'h10);
        exec_dup = 1'b1; tick();
        expect_err(2'd0);
        wb(5'd19, 32'h11);
        tick(); tick();
        ena = 1'b0; tick(); ena = 1'b1; tick(); tick();
        chk("t2_sticky_err", {31'd0, qed_error}, 1);
        chk("t2_sticky_cause", {30'd0, err_cause}, 0);
        chk("t2_pair_count", {16'd0, pair_count}, 0);
        drain("t2_drain");

        // 3: underflow
        do_reset();
        ena = 1'b1; tick();
        exec_dup = 1'b1; tick();
        expect_err(2'd1);
        wb(5'd17, 32'h0);
        tick(); tick();
        chk("t3_err", {31'd0, qed_error}, 1);
        drain("t3_drain");

        // 4: fill to stall threshold, then overflow
        do_reset();
        ena = 1'b1; tick();
        for (int i = 0; i < 11; i++) wb(5'((i % 15) + 1), 32'(i));
        chk("t4_stall_at_11", {31'd0, stall_IF_chk}, 0);
        wb(5'd12, 32'd11);
        chk("t4_stall_at_12", {31'd0, stall_IF_chk}, 1);
        for (int i = 12; i < 16; i++) wb(5'((i % 15) + 1), 32'(i));
        chk("t4_no_err_at_16", {31'd0, qed_error}, 0);
        expect_err(2'd2);
        wb(5'd2, 32'hBEEF);
        tick();
        chk("t4_err", {31'd0, qed_error}, 1);
        chk("t4_stall_in_err", {31'd0, stall_IF_chk}, 0);
        drain("t4_drain");

        // 5: leftover at dup_done
        do_reset();
        ena = 1'b1; tick();
        wb(5'd1, 32'h101); wb(5'd2, 32'h102); wb(5'd3, 32'h103);
        exec_dup = 1'b1; tick();
        wb(5'd17, 32'h101); wb(5'd18, 32'h102);
        expect_err(2'd3);
        dup_done = 1'b1; tick(); dup_done = 1'b0;
        tick(); tick();
        chk("t5_err", {31'd0, qed_error}, 1);
        chk("t5_pair_count", {16'd0, pair_count}, 2);
        drain("t5_drain");

        // 6: flush on ena=0; rd 0/16 never occupy entries
        do_reset();
        ena = 1'b1; tick();
        wb(5'd4, 32'h44); wb(5'd0, 32'h1); wb(5'd16, 32'h2); wb(5'd7, 32'h77);
        ena = 1'b0; tick();
        ena = 1'b1; tick();
        for (int i = 0; i < 11; i++) begin
            wb(5'((i % 15) + 1), 32'(i));
            wb(((i % 2) == 0) ? 5'd0 : 5'd16, 32'hFFFF);
        end
        chk("t6_stall_at_11", {31'd0, stall_IF_chk}, 0);
        wb(5'd9, 32'h99);
        chk("t6_stall_at_12", {31'd0, stall_IF_chk}, 1);
        chk("t6_no_err", {31'd0, qed_error}, 0);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
